// File: rtl/xm23_alu_pkg.sv
// rtl/xm23_alu_pkg.sv - opcode enumeration, PSW bit indices and byte-lane helper for the XM23 ALU
package xm23_alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_ADDC = 5'd1,
    OP_SUB  = 5'd2,
    OP_SUBC = 5'd3,
    OP_DADD = 5'd4,
    OP_CMP  = 5'd5,
    OP_XOR  = 5'd6,
    OP_AND  = 5'd7,
    OP_OR   = 5'd8,
    OP_BIT  = 5'd9,
    OP_BIC  = 5'd10,
    OP_BIS  = 5'd11,
    OP_MOV  = 5'd12,
    OP_SRA  = 5'd13,
    OP_RRC  = 5'd14,
    OP_SWPB = 5'd15,
    OP_SXT  = 5'd16
  } alu_opcode_e;

  localparam int PSW_C   = 0;
  localparam int PSW_Z   = 1;
  localparam int PSW_N   = 2;
  localparam int PSW_SLP = 3;
  localparam int PSW_V   = 4;

  // Byte-mode results keep the destination's upper byte untouched.
  function automatic logic [15:0] byte_merge(input logic byte_mode,
                                             input logic [15:0] d,
                                             input logic [15:0] r);
    return byte_mode ? {d[15:8], r[7:0]} : r;
  endfunction

endpackage

// File: rtl/xm23_alu_if.sv
// rtl/xm23_alu_if.sv - operand/opcode/PSW bus between the XM23 ALU and its driver
interface xm23_alu_if;

  logic [15:0] d_bus;
  logic [15:0] s_bus;
  logic [5:0]  alu_op;
  logic [15:0] psw_in;
  logic        psw_update;
  logic [15:0] alu_out;
  logic [15:0] alu_psw_out;

  modport master (
    output d_bus, s_bus, alu_op, psw_in, psw_update,
    input  alu_out, alu_psw_out
  );

  modport slave (
    input  d_bus, s_bus, alu_op, psw_in, psw_update,
    output alu_out, alu_psw_out
  );

endinterface

// File: rtl/xm23_bcd_digit_adder.sv
// rtl/xm23_bcd_digit_adder.sv - one BCD nibble adder with decimal carry in/out
module xm23_bcd_digit_adder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] sum_o,
  output logic       c_o
);

  logic [4:0] raw_sum;

  assign raw_sum = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, c_i};
  assign c_o     = (raw_sum > 5'd9);
  assign sum_o   = c_o ? (raw_sum[3:0] + 4'd6) : raw_sum[3:0];

endmodule

// File: rtl/xm23_alu.sv
// rtl/xm23_alu.sv - XM23 registered ALU with PSW flag generation; DADD gated by XM23_ALU_DADD_EN
module xm23_alu
  import xm23_alu_pkg::*;
(
  input logic       Clock,
  input logic       Reset_n,
  xm23_alu_if.slave bus
);

  logic        byte_mode;
  alu_opcode_e op;
  logic [15:0] d;
  logic [15:0] s;
  logic        c_in;

  assign byte_mode = bus.alu_op[5];
  assign op        = alu_opcode_e'(bus.alu_op[4:0]);
  assign d         = bus.d_bus;
  assign s         = bus.s_bus;
  assign c_in      = bus.psw_in[PSW_C];

  // Shared adder: subtraction is d + ~s + carry-in, so C=1 means no borrow.
  logic [15:0] addend;
  logic        add_cin;
  logic [16:0] sum_w;
  logic [8:0]  sum_b;
  logic [15:0] add_res;
  logic        add_c;
  logic        add_v;
  logic        a_msb;
  logic        b_msb;
  logic        r_msb;

  always_comb begin
    addend  = s;
    add_cin = 1'b0;
    case (op)
      OP_ADDC:        add_cin = c_in;
      OP_SUB, OP_CMP: begin addend = ~s; add_cin = 1'b1; end
      OP_SUBC:        begin addend = ~s; add_cin = c_in; end
      default:        ;
    endcase
  end

  assign sum_w   = {1'b0, d} + {1'b0, addend} + {16'h0000, add_cin};
  assign sum_b   = {1'b0, d[7:0]} + {1'b0, addend[7:0]} + {8'h00, add_cin};
  assign add_res = byte_merge(byte_mode, d, sum_w[15:0]);
  assign add_c   = byte_mode ? sum_b[8] : sum_w[16];
  assign a_msb   = byte_mode ? d[7] : d[15];
  assign b_msb   = byte_mode ? addend[7] : addend[15];
  assign r_msb   = byte_mode ? sum_b[7] : sum_w[15];
  assign add_v   = (a_msb == b_msb) && (r_msb != a_msb);

`ifdef XM23_ALU_DADD_EN
  logic [15:0] bcd_sum;
  logic [4:0]  bcd_carry;
  logic [15:0] bcd_res;
  logic        bcd_c;

  assign bcd_carry[0] = c_in;

  for (genvar i = 0; i < 4; i++) begin : g_bcd
    xm23_bcd_digit_adder u_digit (
      .a_i   (d[4*i +: 4]),
      .b_i   (s[4*i +: 4]),
      .c_i   (bcd_carry[i]),
      .sum_o (bcd_sum[4*i +: 4]),
      .c_o   (bcd_carry[i+1])
    );
  end

  assign bcd_res = byte_merge(byte_mode, d, bcd_sum);
  assign bcd_c   = byte_mode ? bcd_carry[2] : bcd_carry[4];
`endif

  // res feeds the flags, out_d feeds alu_out; they differ for CMP and BIT.
  logic [15:0] res;
  logic [15:0] alu_out_d;
  logic        upd_c;
  logic        upd_zn;
  logic        upd_v;
  logic        new_c;
  logic        new_v;
  logic        res_z;
  logic        res_n;
  logic [15:0] psw_d;

  always_comb begin
    res       = d;
    alu_out_d = d;
    upd_c     = 1'b0;
    upd_zn    = 1'b0;
    upd_v     = 1'b0;
    new_c     = c_in;
    new_v     = bus.psw_in[PSW_V];
    case (op)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP: begin
        res       = add_res;
        alu_out_d = (op == OP_CMP) ? d : add_res;
        upd_c     = 1'b1;
        upd_zn    = 1'b1;
        upd_v     = 1'b1;
        new_c     = add_c;
        new_v     = add_v;
      end
`ifdef XM23_ALU_DADD_EN
      OP_DADD: begin
        res       = bcd_res;
        alu_out_d = bcd_res;
        upd_c     = 1'b1;
        upd_zn    = 1'b1;
        new_c     = bcd_c;
      end
`endif
      OP_XOR: begin
        res       = byte_merge(byte_mode, d, d ^ s);
        alu_out_d = res;
        upd_zn    = 1'b1;
      end
      OP_AND: begin
        res       = byte_merge(byte_mode, d, d & s);
        alu_out_d = res;
        upd_zn    = 1'b1;
      end
      OP_OR, OP_BIS: begin
        res       = byte_merge(byte_mode, d, d | s);
        alu_out_d = res;
        upd_zn    = 1'b1;
      end
      OP_BIT: begin
        res       = byte_merge(byte_mode, d, d & s);
        upd_zn    = 1'b1;
      end
      OP_BIC: begin
        res       = byte_merge(byte_mode, d, d & ~s);
        alu_out_d = res;
        upd_zn    = 1'b1;
      end
      OP_MOV: alu_out_d = byte_merge(byte_mode, d, s);
      OP_SRA: begin
        res       = byte_mode ? {d[15:8], d[7], d[7:1]} : {d[15], d[15:1]};
        alu_out_d = res;
        upd_c     = 1'b1;
        upd_zn    = 1'b1;
        new_c     = d[0];
      end
      OP_RRC: begin
        res       = byte_mode ? {d[15:8], c_in, d[7:1]} : {c_in, d[15:1]};
        alu_out_d = res;
        upd_c     = 1'b1;
        upd_zn    = 1'b1;
        new_c     = d[0];
      end
      OP_SWPB: alu_out_d = {d[7:0], d[15:8]};
      OP_SXT:  alu_out_d = {{8{d[7]}}, d[7:0]};
      default: alu_out_d = d;
    endcase
  end

  assign res_z = byte_mode ? (res[7:0] == 8'h00) : (res == 16'h0000);
  assign res_n = byte_mode ? res[7] : res[15];

  always_comb begin
    psw_d = bus.psw_in;
    if (bus.psw_update) begin
      if (upd_c) psw_d[PSW_C] = new_c;
      if (upd_zn) begin
        psw_d[PSW_Z] = res_z;
        psw_d[PSW_N] = res_n;
      end
      if (upd_v) psw_d[PSW_V] = new_v;
    end
  end

  logic [15:0] alu_out_q;
  logic [15:0] psw_q;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      alu_out_q <= 16'h0000;
      psw_q     <= 16'h0000;
    end else begin
      alu_out_q <= alu_out_d;
      psw_q     <= psw_d;
    end
  end

  assign bus.alu_out     = alu_out_q;
  assign bus.alu_psw_out = psw_q;

endmodule

// File: tb/tb_xm23_alu.sv
// tb/tb_xm23_alu.sv - self-checking bench for xm23_alu against a behavioural model
module tb_xm23_alu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   check_en = 1'b0;

  logic [15:0] exp_out = 16'h0000;
  logic [15:0] exp_psw = 16'h0000;

  xm23_alu_if bus ();

  xm23_alu dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Model: arithmetic on plain integers in the operand width.
  function automatic logic [31:0] model(input logic [15:0] d, input logic [15:0] s,
                                        input logic [5:0] op, input logic [15:0] psw,
                                        input logic upd);
    int w, mask, half, a, b, sa, sb, t, sr, cin, r, cc, dg, code;
    bit bm, f_zn, f_c, f_v, c, v;
    logic [15:0] out, rv, np;
    bm   = op[5];
    code = int'(op[4:0]);
    w    = bm ? 8 : 16;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    a    = int'(d) & mask;
    b    = int'(s) & mask;
    sa   = (a >= half) ? a - 2*half : a;
    sb   = (b >= half) ? b - 2*half : b;
    cin  = int'(psw[0]);
    c    = psw[0];
    v    = psw[4];
    r    = a;
    f_zn = 0; f_c = 0; f_v = 0;
    out  = d;
    case (code)
      0, 1: begin
        t  = a + b + ((code == 1) ? cin : 0);
        sr = sa + sb + ((code == 1) ? cin : 0);
        r  = t & mask;  c = (t > mask);  v = (sr < -half) || (sr >= half);
        f_zn = 1; f_c = 1; f_v = 1;
      end
      2, 3, 5: begin
        t  = a - b - ((code == 3) ? 1 - cin : 0);
        sr = sa - sb - ((code == 3) ? 1 - cin : 0);
        r  = t & mask;  c = (t >= 0);  v = (sr < -half) || (sr >= half);
        f_zn = 1; f_c = 1; f_v = 1;
      end
`ifdef XM23_ALU_DADD_EN
      4: begin
        r = 0; cc = cin;
        for (int k = 0; k < w/4; k++) begin
          dg = ((a >> (4*k)) & 15) + ((b >> (4*k)) & 15) + cc;
          if (dg > 9) begin dg = dg + 6; cc = 1; end else cc = 0;
          r = r | ((dg & 15) << (4*k));
        end
        c = (cc != 0); f_zn = 1; f_c = 1;
      end
`endif
      6:      begin r = a ^ b; f_zn = 1; end
      7, 9:   begin r = a & b; f_zn = 1; end
      8, 11:  begin r = a | b; f_zn = 1; end
      10:     begin r = a & ~b & mask; f_zn = 1; end
      12:     r = b;
      13:     begin r = (a >> 1) | (a & half); c = (a & 1) != 0; f_zn = 1; f_c = 1; end
      14:     begin r = (a >> 1) | (cin != 0 ? half : 0); c = (a & 1) != 0; f_zn = 1; f_c = 1; end
      default: ;
    endcase
    rv = r[15:0];
    if (code <= 14 && code != 5 && code != 9 && (code != 4 || f_zn))
      out = bm ? {d[15:8], rv[7:0]} : rv;
    if (code == 15) out = {d[7:0], d[15:8]};
    if (code == 16) out = {{8{d[7]}}, d[7:0]};
    np = psw;
    if (upd && f_zn) begin
      np[1] = (r == 0);
      np[2] = (r & half) != 0;
      if (f_c) np[0] = c;
      if (f_v) np[4] = v;
    end
    return {out, np};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) {exp_out, exp_psw} = 32'h0;
    else {exp_out, exp_psw} = model(bus.d_bus, bus.s_bus, bus.alu_op, bus.psw_in, bus.psw_update);
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_alu_out", bus.alu_out, exp_out);
      chk("model_alu_psw_out", bus.alu_psw_out, exp_psw);
    end
  end

  task automatic apply(input logic [5:0] op, input logic [15:0] d, input logic [15:0] s,
                       input logic [15:0] psw, input logic upd);
    bus.alu_op     = op;
    bus.d_bus      = d;
    bus.s_bus      = s;
    bus.psw_in     = psw;
    bus.psw_update = upd;
    @(negedge clk);
  endtask

  logic [15:0] sw_d [4] = '{16'h7FFF, 16'h8001, 16'h0990, 16'hFF80};
  logic [15:0] sw_s [4] = '{16'h0001, 16'h8001, 16'h0019, 16'h00FF};
  logic [15:0] sw_p [4] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h0110};

  initial begin
    bus.alu_op = 6'h00; bus.d_bus = 16'h0; bus.s_bus = 16'h0;
    bus.psw_in = 16'h0; bus.psw_update = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_alu_out", bus.alu_out, 16'h0000);
    chk("reset_psw", bus.alu_psw_out, 16'h0000);
    rst_n = 1'b1;
    check_en = 1'b1;

    apply(6'h00, 16'h7FFF, 16'h0001, 16'h0000, 1'b1);
    chk("add_ovf_out", bus.alu_out, 16'h8000);
    chk("add_ovf_psw", bus.alu_psw_out, 16'h0014);

    apply(6'h22, 16'h1205, 16'h0005, 16'h0000, 1'b1);
    chk("subb_out", bus.alu_out, 16'h1200);
    chk("subb_psw", bus.alu_psw_out, 16'h0003);

    apply(6'h04, 16'h9999, 16'h0001, 16'h0010, 1'b1);
`ifdef XM23_ALU_DADD_EN
    chk("dadd_out", bus.alu_out, 16'h0000);
    chk("dadd_psw", bus.alu_psw_out, 16'h0013);
`else
    chk("dadd_off_out", bus.alu_out, 16'h9999);
    chk("dadd_off_psw", bus.alu_psw_out, 16'h0010);
`endif

    apply(6'h0E, 16'h0001, 16'h0000, 16'h0001, 1'b1);
    chk("rrc_out", bus.alu_out, 16'h8000);
    chk("rrc_psw", bus.alu_psw_out, 16'h0005);
    apply(6'h0E, 16'h0001, 16'h0000, 16'h0001, 1'b0);
    chk("rrc_noupd_out", bus.alu_out, 16'h8000);
    chk("rrc_noupd_psw", bus.alu_psw_out, 16'h0001);

    apply(6'h05, 16'h0003, 16'h0004, 16'h60E0, 1'b1);
    chk("cmp_out", bus.alu_out, 16'h0003);
    chk("cmp_psw", bus.alu_psw_out, 16'h60E4);

    apply(6'h1F, 16'h1234, 16'h5678, 16'h00FF, 1'b1);
    chk("bad_op_out", bus.alu_out, 16'h1234);
    chk("bad_op_psw", bus.alu_psw_out, 16'h00FF);

    apply(6'h2F, 16'h1234, 16'h0000, 16'h0000, 1'b1);
    chk("swpb_byte_out", bus.alu_out, 16'h3412);
    apply(6'h10, 16'h0080, 16'h0000, 16'h0000, 1'b1);
    chk("sxt_out", bus.alu_out, 16'hFF80);
    apply(6'h2C, 16'hAB12, 16'h0034, 16'h0000, 1'b1);
    chk("movb_out", bus.alu_out, 16'hAB34);
    apply(6'h0D, 16'h8003, 16'h0000, 16'h0000, 1'b1);
    chk("sra_out", bus.alu_out, 16'hC001);
    chk("sra_psw", bus.alu_psw_out, 16'h0005);
    apply(6'h09, 16'hF0F0, 16'h0F0F, 16'h0011, 1'b1);
    chk("bit_out", bus.alu_out, 16'hF0F0);
    chk("bit_psw", bus.alu_psw_out, 16'h0013);
    apply(6'h21, 16'h00FF, 16'h0000, 16'h0001, 1'b1);
    chk("addcb_out", bus.alu_out, 16'h0000);
    chk("addcb_psw", bus.alu_psw_out, 16'h0003);
    apply(6'h03, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    chk("subc_out", bus.alu_out, 16'hFFFF);
    chk("subc_psw", bus.alu_psw_out, 16'h0004);

    for (int op = 0; op < 64; op++)
      for (int k = 0; k < 4; k++)
        apply(op[5:0], sw_d[k], sw_s[k], sw_p[k], logic'(k != 3));

    apply(6'h0C, 16'h0000, 16'hBEEF, 16'h0000, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", bus.alu_out, 16'h0000);
    chk("async_rst_psw", bus.alu_psw_out, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    apply(6'h00, 16'h0002, 16'h0003, 16'h0000, 1'b1);
    chk("post_rst_out", bus.alu_out, 16'h0005);
    chk("post_rst_psw", bus.alu_psw_out, 16'h0000);

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
